shift_sequencer: RTL

Multi-cycle logical shift engine that sits directly upstream of the team's single-bit combinational shifter and drives it one step per clock. Accepts an operand, a direction and a shift amount via a valid/ready handshake. Applies one 1-bit logical shift per cycle, stopping early once the operand becomes zero. Returns the result and the number of shifts actually performed through a second valid/ready handshake.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_unit.sv | 16 +
 rtl/shift_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and direction constants for shift_sequencer
package shift_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    SHIFT = S_SHIFT,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - combinational single-bit logical shifter, both directions
//   x   : operand
//   shl : x << 1, zero fill
//   shr : x >> 1, zero fill
module shift_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] shl,
  output logic [WIDTH-1:0] shr
);

  assign shl = {x[WIDTH-2:0], 1'b0};
  assign shr = {1'b0, x[WIDTH-1:1]};

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle logical shift engine with early stop on zero
//   start_valid/start_ready : request handshake, captures din, dir, amount
//   busy                    : operation in flight or result pending
//   dout/steps              : result operand and number of shifts performed
//   dout_valid/dout_ready   : result handshake
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] steps,
  output logic             dout_valid,
  input  logic             dout_ready
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic [CNT_W-1:0] steps_q;

  logic [WIDTH-1:0] shl, shr, shifted;

  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .x   (data_q),
    .shl (shl),
    .shr (shr)
  );

  assign shifted = (dir_q == DIR_RIGHT) ? shr : shl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          // nothing to do for a zero amount or a zero operand: report at once
          state_d = (amount == '0 || din == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // stop on the last requested shift, or as soon as the operand empties
        if (cnt_q == CNT_W'(1) || shifted == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (dout_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      steps_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            data_q  <= din;
            cnt_q   <= amount;
            dir_q   <= dir;
            steps_q <= '0;
          end
        end
        SHIFT: begin
          data_q  <= shifted;
          cnt_q   <= cnt_q - CNT_W'(1);
          steps_q <= steps_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign dout_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign dout        = data_q;
  assign steps       = steps_q;

endmodule
